// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline forwarding, load-use/branch hazards and multi-cycle op sequencing (optional HAZARD_PERF_CNT_EN adds StallCnt/FlushCnt)
module hazard_ctrl #(
  parameter int MUL_TIMEOUT = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       LoadE,
  input  logic       PCsrcE,
  input  logic       MulE,
  input  logic       MulDone,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       MulStart,
  output logic       MulErr
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt
`endif
);
  typedef enum logic [1:0] {RUN, MUL_WAIT, MUL_DRAIN} state_t;
  state_t state, nextState;
  logic [5:0] cnt;
  logic loadUse, timeout;
  assign loadUse = LoadE && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
  assign timeout = cnt == 6'(MUL_TIMEOUT - 1);
  // operand forwarding: the younger Memory result wins over Writeback
  always_comb begin
    ForwardAE = (RegWriteM && RdM != 5'd0 && RdM == Rs1E) ? 2'b10 : (RegWriteW && RdW != 5'd0 && RdW == Rs1E) ? 2'b01 : 2'b00;
    ForwardBE = (RegWriteM && RdM != 5'd0 && RdM == Rs2E) ? 2'b10 : (RegWriteW && RdW != 5'd0 && RdW == Rs2E) ? 2'b01 : 2'b00;
  end
  // next state and stall/flush outputs; reset forces every control output low
  always_comb begin
    nextState = state;
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    MulStart = 1'b0;
    MulErr = 1'b0;
    case (state)
      RUN: begin
        if (PCsrcE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else begin
          if (loadUse) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
          end
          if (MulE) begin
            MulStart = 1'b1;
            nextState = MUL_WAIT;
          end
        end
      end
      MUL_WAIT: begin
        StallF = 1'b1;
        StallD = 1'b1;
        if (MulDone) begin
          StallE = 1'b1;
          nextState = MUL_DRAIN;
        end else if (timeout) begin
          MulErr = 1'b1;
          FlushE = 1'b1;
          nextState = RUN;
        end else begin
          StallE = 1'b1;
        end
      end
      default: nextState = RUN;
    endcase
    if (rst) begin
      nextState = RUN;
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      MulStart = 1'b0;
      MulErr = 1'b0;
    end
  end
  // state register and wait counter, cleared on start and on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt <= 6'd0;
    end else begin
      state <= nextState;
      cnt <= MulStart ? 6'd0 : (state == MUL_WAIT) ? cnt + 6'd1 : cnt;
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  // free-running wrap-around event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      StallCnt <= 32'd0;
      FlushCnt <= 32'd0;
    end else begin
      StallCnt <= StallCnt + 32'(StallF);
      FlushCnt <= FlushCnt + 32'(FlushD | FlushE);
    end
  end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: randomized scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;
  localparam int TO = 40;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0, RdM = '0, RdW = '0;
  logic RegWriteM = 0, RegWriteW = 0, LoadE = 0, PCsrcE = 0, MulE = 0, MulDone = 0;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, FlushD, FlushE, MulStart, MulErr;
  logic [31:0] StallCnt, FlushCnt;
  hazard_ctrl #(.MUL_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .LoadE(LoadE),
    .PCsrcE(PCsrcE), .MulE(MulE), .MulDone(MulDone), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE),
    .MulStart(MulStart), .MulErr(MulErr)
`ifdef HAZARD_PERF_CNT_EN
    , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
  );
`ifndef HAZARD_PERF_CNT_EN
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif
  always #5 clk = ~clk;
  typedef struct {
    logic [12:0] v;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0, cyc = 0, errSeen = 0, startSeen = 0;
  // reference model: -1 means no multi-cycle op outstanding, else cycles already waited
  int waitN = -1;
  bit draining = 0;
  logic [31:0] mSc = 0, mFc = 0;
  function automatic logic [1:0] fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction
  task automatic step(input int mulP, input int doneP, input int rstP, input int pcP, input bit forceRst);
    bit sf, sd, se, fd, fe, ms, me, ld;
    exp_t e;
    @(posedge clk);
    #1;
    rst = forceRst || ($urandom_range(0, 99) < rstP);
    Rs1D = 5'($urandom_range(0, 7)); Rs2D = 5'($urandom_range(0, 7));
    Rs1E = 5'($urandom_range(0, 7)); Rs2E = 5'($urandom_range(0, 7));
    RdE = 5'($urandom_range(0, 7)); RdM = 5'($urandom_range(0, 7)); RdW = 5'($urandom_range(0, 7));
    RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
    LoadE = ($urandom_range(0, 99) < 30);
    PCsrcE = ($urandom_range(0, 99) < pcP);
    MulE = ($urandom_range(0, 99) < mulP);
    MulDone = ($urandom_range(0, 99) < doneP);
    {sf, sd, se, fd, fe, ms, me} = '0;
    ld = LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    if (rst) begin
      waitN = -1;
      draining = 0;
    end else if (draining) begin
      draining = 0;
    end else if (waitN >= 0) begin
      sf = 1; sd = 1;
      if (MulDone) begin
        se = 1; draining = 1; waitN = -1;
      end else if (waitN + 1 == TO) begin
        fe = 1; me = 1; waitN = -1;
      end else begin
        se = 1; waitN++;
      end
    end else if (PCsrcE) begin
      fd = 1; fe = 1;
    end else begin
      if (ld) begin sf = 1; sd = 1; fe = 1; end
      if (MulE) begin ms = 1; waitN = 0; end
    end
    errSeen += me;
    startSeen += ms;
    e.v = {fwd(Rs1E), fwd(Rs2E), sf, sd, se, fd, fe, ms, me};
    e.sc = mSc;
    e.fc = mFc;
    q.push_back(e);
    mSc = rst ? 0 : mSc + 32'(sf);
    mFc = rst ? 0 : mFc + 32'(fd | fe);
  endtask
  // monitor: every cycle the DUT presents a response for the vector driven in it
  always @(negedge clk) begin
    exp_t e;
    logic [12:0] act;
    cyc++;
    if (q.size() != 0) begin
      e = q.pop_front();
      act = {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, MulStart, MulErr};
      vectors++;
      if (act !== e.v) begin
        miscompares++;
        $display("FAIL outputs cycle %0d: got %b expected %b (fa fb sf sd se fd fe ms me)", cyc, act, e.v);
      end
      vectors++;
      if ((StallE & FlushE) !== 1'b0) begin
        miscompares++;
        $display("FAIL stallE_flushE_exclusive cycle %0d: got %b%b expected not both 1", cyc, StallE, FlushE);
      end
`ifdef HAZARD_PERF_CNT_EN
      vectors++;
      if (StallCnt !== e.sc || FlushCnt !== e.fc) begin
        miscompares++;
        $display("FAIL perf_counters cycle %0d: got %0d/%0d expected %0d/%0d", cyc, StallCnt, FlushCnt, e.sc, e.fc);
      end
`endif
    end
  end
  initial begin
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    for (int i = 0; i < 600; i++) step(20, 20, 1, 15, 0);
    for (int i = 0; i < 300; i++) step(50, 0, 0, 10, 0);
    for (int i = 0; i < 400; i++) step(30, 15, 5, 15, 0);
    for (int i = 0; i < 200; i++) step(40, 0, 2, 5, 0);
    repeat (2) @(posedge clk);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    vectors++;
    if (errSeen == 0 || startSeen == 0) begin
      miscompares++;
      $display("FAIL coverage: got %0d timeouts %0d starts expected both nonzero", errSeen, startSeen);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
